// File: rtl/tcm_ext_loader_pkg.sv
// Shared types for the TCM external-port loader: FSM states and error codes.
package sophon_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WR,
    S_RD,
    S_CHECK,
    S_DONE,
    S_ERR
  } loader_state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_BUS  = 2'd1,
    ERR_TO   = 2'd2,
    ERR_CSUM = 2'd3
  } err_code_e;

endpackage

// File: rtl/tcm_ext_loader_ack_timer.sv
// Ack-wait down-counter: reloads to ACK_TO on clr, counts while en, flags expiry at terminal count.
module loader_ack_timer #(
  parameter int unsigned ACK_TO = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = (ACK_TO < 2) ? 1 : $clog2(ACK_TO + 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= TW'(ACK_TO);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  // ACK_TO == 0 disables the timeout entirely.
  assign expired = (ACK_TO != 0) && en && (cnt_q == TW'(1));

endmodule

// File: rtl/tcm_ext_loader.sv
// Loads a program image into ITCM/DTCM over the core's external-access port,
// optionally verifies it by read-back checksum, and releases core reset on success.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start_i after reset
// FETCH  | source ready high, waiting for the next word
// WR     | write request outstanding for word idx
// RD     | read-back request outstanding for word idx
// CHECK  | compare read-back sum against written sum
// DONE   | load good, core reset released; start_i re-arms
// ERR    | load aborted, err_code_o holds cause; start_i re-arms
module tcm_ext_loader
  import sophon_loader_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter int          CNT_W  = 16,
  parameter int unsigned ACK_TO = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_cnt_i,
  input  logic              verify_en_i,
  input  logic              src_valid_i,
  input  logic [31:0]       src_data_i,
  output logic              src_ready_o,
  output logic              ext_req_o,
  output logic              ext_we_o,
  output logic [ADDR_W-1:0] ext_addr_o,
  output logic [31:0]       ext_wdata_o,
  input  logic              ext_ack_i,
  input  logic              ext_error_i,
  input  logic [31:0]       ext_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [31:0]       checksum_o,
  output logic              core_rst_no
);

  loader_state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  idx_nxt;
  logic              ver_q;
  logic [31:0]       data_q;
  logic [31:0]       wsum_q;
  logic [31:0]       rsum_q;
  err_code_e         err_code_q;

  logic in_bus;
  logic last_word;
  logic start_acc;
  logic fetch_hs;
  logic wr_ok;
  logic rd_ok;
  logic bus_err;
  logic to_err;
  logic csum_err;
  logic tmr_clr;
  logic tmr_expired;

  assign in_bus    = (state_q == S_WR) || (state_q == S_RD);
  assign idx_nxt   = idx_q + CNT_W'(1);
  assign last_word = (idx_nxt == cnt_q);

  loader_ack_timer #(
    .ACK_TO (ACK_TO)
  ) u_ack_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (in_bus),
    .expired (tmr_expired)
  );

  // Reload on every ack so back-to-back reads each get a full timeout window.
  assign tmr_clr = !in_bus || ext_ack_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    fetch_hs  = 1'b0;
    wr_ok     = 1'b0;
    rd_ok     = 1'b0;
    bus_err   = 1'b0;
    to_err    = 1'b0;
    csum_err  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = (word_cnt_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (src_valid_i) begin
          fetch_hs = 1'b1;
          state_d  = S_WR;
        end
      end
      S_WR: begin
        if (ext_ack_i) begin
          if (ext_error_i) begin
            bus_err = 1'b1;
            state_d = S_ERR;
          end else begin
            wr_ok = 1'b1;
            if (last_word) begin
              state_d = ver_q ? S_RD : S_DONE;
            end else begin
              state_d = S_FETCH;
            end
          end
        end else if (tmr_expired) begin
          to_err  = 1'b1;
          state_d = S_ERR;
        end
      end
      S_RD: begin
        if (ext_ack_i) begin
          if (ext_error_i) begin
            bus_err = 1'b1;
            state_d = S_ERR;
          end else begin
            rd_ok = 1'b1;
            if (last_word) begin
              state_d = S_CHECK;
            end
          end
        end else if (tmr_expired) begin
          to_err  = 1'b1;
          state_d = S_ERR;
        end
      end
      S_CHECK: begin
        if (rsum_q == wsum_q) begin
          state_d = S_DONE;
        end else begin
          csum_err = 1'b1;
          state_d  = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      cnt_q      <= '0;
      ver_q      <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      wsum_q     <= '0;
      rsum_q     <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      if (start_acc) begin
        base_q     <= base_addr_i;
        cnt_q      <= word_cnt_i;
        ver_q      <= verify_en_i;
        idx_q      <= '0;
        wsum_q     <= '0;
        rsum_q     <= '0;
        err_code_q <= ERR_NONE;
      end
      if (fetch_hs) begin
        data_q <= src_data_i;
        wsum_q <= wsum_q + src_data_i;
      end
      if (wr_ok) begin
        if (last_word) begin
          idx_q  <= '0;
          rsum_q <= '0;
        end else begin
          idx_q <= idx_nxt;
        end
      end
      if (rd_ok) begin
        rsum_q <= rsum_q + ext_rdata_i;
        idx_q  <= idx_nxt;
      end
      if (bus_err) begin
        err_code_q <= ERR_BUS;
      end
      if (to_err) begin
        err_code_q <= ERR_TO;
      end
      if (csum_err) begin
        err_code_q <= ERR_CSUM;
      end
    end
  end

  // Byte address of word idx; wraps modulo 2^ADDR_W by design.
  assign ext_addr_o  = base_q + ADDR_W'({idx_q, 2'b00});
  assign ext_wdata_o = data_q;
  assign ext_req_o   = in_bus;
  assign ext_we_o    = (state_q == S_WR);
  assign src_ready_o = (state_q == S_FETCH);
  assign busy_o      = (state_q == S_FETCH) || in_bus || (state_q == S_CHECK);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_ERR);
  assign err_code_o  = err_code_q;
  assign checksum_o  = wsum_q;
  assign core_rst_no = (state_q == S_DONE);

endmodule

// File: tb/tb_tcm_ext_loader.sv
// Directed bench for tcm_ext_loader with a behavioural bus slave and source stream.
module tb_tcm_ext_loader;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;
  localparam int ACK_TO = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [CNT_W-1:0]  word_cnt_i = '0;
  logic              verify_en_i = 1'b0;
  logic              src_valid_i = 1'b0;
  logic [31:0]       src_data_i = '0;
  logic              src_ready_o;
  logic              ext_req_o;
  logic              ext_we_o;
  logic [ADDR_W-1:0] ext_addr_o;
  logic [31:0]       ext_wdata_o;
  logic              ext_ack_i = 1'b0;
  logic              ext_error_i = 1'b0;
  logic [31:0]       ext_rdata_i = '0;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [1:0]        err_code_o;
  logic [31:0]       checksum_o;
  logic              core_rst_no;

  tcm_ext_loader #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .ACK_TO (ACK_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .word_cnt_i  (word_cnt_i),
    .verify_en_i (verify_en_i),
    .src_valid_i (src_valid_i),
    .src_data_i  (src_data_i),
    .src_ready_o (src_ready_o),
    .ext_req_o   (ext_req_o),
    .ext_we_o    (ext_we_o),
    .ext_addr_o  (ext_addr_o),
    .ext_wdata_o (ext_wdata_o),
    .ext_ack_i   (ext_ack_i),
    .ext_error_i (ext_error_i),
    .ext_rdata_i (ext_rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_code_o  (err_code_o),
    .checksum_o  (checksum_o),
    .core_rst_no (core_rst_no)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Source stream: presents queue head, pops after a handshake.
  logic [31:0] src_q[$];
  int          stall = 0;
  bit          hs = 1'b0;

  initial forever begin
    @(negedge clk);
    if (hs && (src_q.size() > 0)) void'(src_q.pop_front());
    if (stall > 0) begin
      stall--;
      src_valid_i = 1'b0;
    end else if (src_q.size() > 0) begin
      src_valid_i = 1'b1;
      src_data_i  = src_q[0];
    end else begin
      src_valid_i = 1'b0;
    end
    hs = src_valid_i && src_ready_o;
  end

  // Bus slave: acks one cycle after seeing a request, single-cycle ack pulse.
  bit          slave_en = 1'b1;
  int          err_wr = -1;
  int          bad_rd = -1;
  int          wr_n = 0;
  int          rd_n = 0;
  int          req_rises = 0;
  int          wt = 0;
  bit          prev_req = 1'b0;
  logic [31:0] wr_log[$];
  logic [31:0] mem[logic [31:0]];

  initial forever begin
    @(negedge clk);
    if (ext_req_o && !prev_req) req_rises++;
    prev_req = ext_req_o;
    if (ext_ack_i) begin
      ext_ack_i   = 1'b0;
      ext_error_i = 1'b0;
      wt          = 0;
    end else if (ext_req_o && slave_en) begin
      if (wt < 1) begin
        wt++;
      end else begin
        wt        = 0;
        ext_ack_i = 1'b1;
        if (ext_we_o) begin
          ext_error_i = (wr_n == err_wr);
          if (!ext_error_i) begin
            mem[ext_addr_o] = ext_wdata_o;
            wr_log.push_back(ext_addr_o);
          end
          wr_n++;
        end else begin
          if (rd_n == bad_rd) ext_rdata_i = 32'h0;
          else if (mem.exists(ext_addr_o)) ext_rdata_i = mem[ext_addr_o];
          else ext_rdata_i = 32'h0;
          rd_n++;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_tb();
    src_q.delete();
    wr_log.delete();
    wr_n = 0;
    rd_n = 0;
    req_rises = 0;
  endtask

  task automatic start_load(input logic [31:0] base, input int cnt, input bit ver);
    base_addr_i = base;
    word_cnt_i  = CNT_W'(cnt);
    verify_en_i = ver;
    start_i     = 1'b1;
    step();
    start_i     = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n;
    n = 0;
    while (!(done_o || err_o) && (n < budget)) begin
      step();
      n++;
    end
    chk(tag, 32'(done_o || err_o), 32'd1);
  endtask

  task automatic wait_req(input int budget, input string tag);
    int n;
    n = 0;
    while (!ext_req_o && (n < budget)) begin
      step();
      n++;
    end
    chk(tag, 32'(ext_req_o), 32'd1);
  endtask

  initial begin
    int t_req;
    int t_err;

    // Reset state
    step();
    step();
    chk("rst_req", 32'(ext_req_o), 32'd0);
    chk("rst_ready", 32'(src_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done_err", {30'd0, done_o, err_o}, 32'd0);
    chk("rst_core", 32'(core_rst_no), 32'd0);
    chk("rst_csum", checksum_o, 32'd0);
    rst_n = 1'b1;
    step();

    // Write only, with an ignored start pulse mid-load
    clear_tb();
    src_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    start_load(32'h8000_0000, 4, 1'b0);
    chk("wo_busy", 32'(busy_o), 32'd1);
    chk("wo_core_low", 32'(core_rst_no), 32'd0);
    step();
    step();
    start_load(32'h0000_5000, 1, 1'b0);
    wait_end(200, "wo_end");
    chk("wo_nwr", 32'(wr_log.size()), 32'd4);
    chk("wo_a0", wr_log[0], 32'h8000_0000);
    chk("wo_a1", wr_log[1], 32'h8000_0004);
    chk("wo_a2", wr_log[2], 32'h8000_0008);
    chk("wo_a3", wr_log[3], 32'h8000_000C);
    chk("wo_csum", checksum_o, 32'h0000_000A);
    chk("wo_done", 32'(done_o), 32'd1);
    chk("wo_core", 32'(core_rst_no), 32'd1);
    chk("wo_nrd", 32'(rd_n), 32'd0);

    // Verify pass with mod-2^32 wrap of the sum
    clear_tb();
    src_q = '{32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_FFFF};
    start_load(32'h0000_1000, 3, 1'b1);
    wait_end(300, "vf_end");
    chk("vf_csum", checksum_o, 32'hDEAD_BEEF);
    chk("vf_done", 32'(done_o), 32'd1);
    chk("vf_nrd", 32'(rd_n), 32'd3);
    chk("vf_core", 32'(core_rst_no), 32'd1);

    // Checksum mismatch: second read returns zero
    clear_tb();
    bad_rd = 1;
    src_q = '{32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_FFFF};
    start_load(32'h0000_1000, 3, 1'b1);
    wait_end(300, "cm_end");
    chk("cm_err", 32'(err_o), 32'd1);
    chk("cm_code", 32'(err_code_o), 32'd3);
    chk("cm_core", 32'(core_rst_no), 32'd0);
    chk("cm_done", 32'(done_o), 32'd0);
    bad_rd = -1;

    // Bus error on the second write
    clear_tb();
    err_wr = 1;
    src_q = '{32'd5, 32'd6, 32'd7, 32'd8};
    start_load(32'h0000_2000, 4, 1'b0);
    wait_end(200, "be_end");
    chk("be_err", 32'(err_o), 32'd1);
    chk("be_code", 32'(err_code_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("be_ready_low", 32'(src_ready_o), 32'd0);
    end
    chk("be_req_low", 32'(ext_req_o), 32'd0);
    chk("be_nreq", 32'(req_rises), 32'd2);
    chk("be_csum", checksum_o, 32'h0000_000B);
    err_wr = -1;

    // Ack timeout
    clear_tb();
    slave_en = 1'b0;
    src_q = '{32'h77, 32'h78};
    start_load(32'h0000_3000, 2, 1'b0);
    wait_req(20, "to_req");
    t_req = cyc;
    wait_end(50, "to_end");
    t_err = cyc;
    chk("to_latency", 32'(t_err - t_req), 32'd8);
    chk("to_code", 32'(err_code_o), 32'd2);
    chk("to_req_low", 32'(ext_req_o), 32'd0);
    chk("to_core", 32'(core_rst_no), 32'd0);
    slave_en = 1'b1;

    // Zero-length load from ERR
    clear_tb();
    start_load(32'h0000_6000, 0, 1'b1);
    chk("z_done", 32'(done_o), 32'd1);
    chk("z_err", 32'(err_o), 32'd0);
    chk("z_code", 32'(err_code_o), 32'd0);
    chk("z_csum", checksum_o, 32'd0);
    chk("z_core", 32'(core_rst_no), 32'd1);
    step();
    step();
    chk("z_noreq", 32'(req_rises), 32'd0);

    // Source stalled for 5 cycles
    clear_tb();
    src_q = '{32'h0000_000A, 32'h0000_000B};
    stall = 5;
    start_load(32'h0000_4000, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("st_req_low", 32'(ext_req_o), 32'd0);
      if (i < 4) step();
    end
    wait_end(200, "st_end");
    chk("st_done", 32'(done_o), 32'd1);
    chk("st_csum", checksum_o, 32'h0000_0015);

    // Asynchronous reset mid-write
    clear_tb();
    slave_en = 1'b0;
    src_q = '{32'h1234_5678};
    start_load(32'h0000_7000, 1, 1'b0);
    wait_req(20, "ar_req");
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(ext_req_o), 32'd0);
    chk("ar_busy", 32'(busy_o), 32'd0);
    chk("ar_ready", 32'(src_ready_o), 32'd0);
    chk("ar_addr", ext_addr_o, 32'd0);
    chk("ar_csum", checksum_o, 32'd0);
    chk("ar_core", 32'(core_rst_no), 32'd0);
    step();
    rst_n = 1'b1;
    slave_en = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
